// File: rtl/dbg_input_port_pkg.sv
// dbg_input_port shared definitions.
// Register offsets, default base address and bus decode helper.
package dbg_input_port_pkg;

  localparam logic [31:0] DBG_IN_LEVEL = 32'h0;
  localparam logic [31:0] DBG_IN_EVENT = 32'h4;
  localparam logic [31:0] DBG_IN_MASK  = 32'h8;

  // Sits right above the LED output register at $7ff0.
  localparam logic [31:0] DBG_IN_BASE  = 32'h0000_7ff4;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_LEVEL,
    SEL_EVENT,
    SEL_MASK
  } reg_sel_e;

  function automatic reg_sel_e dbg_in_decode(
    input logic [31:0] adrs,
    input logic [31:0] base
  );
    reg_sel_e sel;
    sel = SEL_NONE;
    unique case (1'b1)
      (adrs == base + DBG_IN_LEVEL): sel = SEL_LEVEL;
      (adrs == base + DBG_IN_EVENT): sel = SEL_EVENT;
      (adrs == base + DBG_IN_MASK):  sel = SEL_MASK;
      default:                       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dbg_tick_gen.sv
// Debounce sample strobe: one-cycle tick every DB_CYCLES clocks.
// Counter runs 0..DB_CYCLES-1 and wraps.
module dbg_tick_gen #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dbg_input_port.sv
// Memory-mapped switch/button input port: sync, debounce,
// sticky rising-edge events, maskable level interrupt.
module dbg_input_port
  import dbg_input_port_pkg::*;
#(
  parameter int          WIDTH     = 10,
  parameter int          DB_CYCLES = 50000,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADRS = DBG_IN_BASE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [31:0]      adrs,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             irq
);

  localparam int PAD = 32 - WIDTH;

  logic             tick;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] samp_prev_q;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] event_q, event_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             irq_q, irq_d;
  reg_sel_e         sel;
  logic             unused_wr;

  assign unused_wr = ^wr_data[31:WIDTH];

  dbg_tick_gen #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign sel = dbg_in_decode(adrs, BASE_ADRS);

  // A bit only moves once two consecutive samples agree.
  assign stable  = ~(sync2_q ^ samp_prev_q);
  assign level_d = tick ? ((level_q & ~stable) | (sync2_q & stable))
                        : level_q;
  assign rise    = level_d & ~level_q;

  always_comb begin
    event_d = event_q | rise;
    mask_d  = mask_q;
    if (wr_en && sel == SEL_EVENT) begin
      event_d = (event_q & ~wr_data[WIDTH-1:0]) | rise;
    end
    if (wr_en && sel == SEL_MASK) begin
      mask_d = wr_data[WIDTH-1:0];
    end
  end

  assign irq_d = |(event_d & mask_d);

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (rd_en) begin
      unique case (sel)
        SEL_LEVEL: begin
          rd_data_d  = {{PAD{1'b0}}, level_q};
          rd_valid_d = 1'b1;
        end
        SEL_EVENT: begin
          rd_data_d  = {{PAD{1'b0}}, event_q};
          rd_valid_d = 1'b1;
        end
        SEL_MASK: begin
          rd_data_d  = {{PAD{1'b0}}, mask_q};
          rd_valid_d = 1'b1;
        end
        default: begin
          rd_data_d  = rd_data_q;
          rd_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      samp_prev_q <= '0;
      level_q     <= '0;
      event_q     <= '0;
      mask_q      <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      sync1_q     <= sw_in;
      sync2_q     <= sync1_q;
      if (tick) begin
        samp_prev_q <= sync2_q;
      end
      level_q     <= level_d;
      event_q     <= event_d;
      mask_q      <= mask_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      irq_q       <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_dbg_input_port.sv
// Bench for dbg_input_port: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_dbg_input_port;

  localparam int          W    = 10;
  localparam int          DB   = 4;
  localparam logic [31:0] BASE = 32'h7ff4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [W-1:0]  sw_in = '0;
  logic [31:0]   adrs = '0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          irq;

  always #5 clk = ~clk;

  dbg_input_port #(
    .WIDTH     (W),
    .DB_CYCLES (DB),
    .CNT_W     (16),
    .BASE_ADRS (BASE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw_in    (sw_in),
    .adrs     (adrs),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .irq      (irq)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int unsigned  m_ncyc;
  logic [W-1:0] m_pipe[2];
  logic [W-1:0] m_prev, m_lvl, m_evt, m_mask;
  logic         m_irq, m_rv;
  logic [31:0]  m_rd;

  task automatic mdl_reset();
    m_ncyc = 0;
    m_pipe[0] = '0;
    m_pipe[1] = '0;
    m_prev = '0;
    m_lvl = '0;
    m_evt = '0;
    m_mask = '0;
    m_irq = 1'b0;
    m_rv = 1'b0;
    m_rd = '0;
  endtask

  task automatic mdl_step();
    bit           is_tick;
    logic [W-1:0] seen, nl, ne, nm, rise;
    logic [31:0]  regs[3];
    int           idx;
    is_tick = (m_ncyc % DB) == (DB - 1);
    seen = m_pipe[1];
    nl = m_lvl;
    if (is_tick) begin
      for (int i = 0; i < W; i++)
        if (seen[i] == m_prev[i]) nl[i] = seen[i];
      m_prev = seen;
    end
    rise = nl & ~m_lvl;
    idx = -1;
    if (adrs == BASE) idx = 0;
    else if (adrs == BASE + 4) idx = 1;
    else if (adrs == BASE + 8) idx = 2;
    ne = m_evt | rise;
    nm = m_mask;
    if (wr_en && idx == 1) ne = (m_evt & ~wr_data[W-1:0]) | rise;
    if (wr_en && idx == 2) nm = wr_data[W-1:0];
    regs[0] = 32'(m_lvl);
    regs[1] = 32'(m_evt);
    regs[2] = 32'(m_mask);
    m_rv = rd_en && idx >= 0;
    if (m_rv) m_rd = regs[idx];
    m_irq = |(ne & nm);
    m_lvl = nl;
    m_evt = ne;
    m_mask = nm;
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = sw_in;
    m_ncyc++;
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_step();
    #1;
    expect_eq("rd_valid", 32'(rd_valid), 32'(m_rv));
    expect_eq("irq", 32'(irq), 32'(m_irq));
    expect_eq("rd_data", rd_data, m_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic rd(input logic [31:0] a);
    adrs = a;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adrs = a;
    wr_data = d;
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    bit found;
    logic [31:0] pick[6];
    mdl_reset();
    #3;
    expect_eq("rst_rd_data", rd_data, 32'h0);
    expect_eq("rst_rd_valid", 32'(rd_valid), 32'h0);
    expect_eq("rst_irq", 32'(irq), 32'h0);
    #20;
    reset_n = 1'b1;

    rd(BASE);
    expect_eq("rst_level", rd_data, 32'h0);
    expect_eq("rv_pulse", 32'(rd_valid), 32'h1);
    rd(BASE + 4);
    expect_eq("rst_event", rd_data, 32'h0);
    rd(BASE + 8);
    expect_eq("rst_mask", rd_data, 32'h0);
    idle(1);
    expect_eq("rv_drop", 32'(rd_valid), 32'h0);

    sw_in = 10'h005;
    idle(10);
    rd(BASE);
    expect_eq("level_5", rd_data, 32'h5);
    rd(BASE + 4);
    expect_eq("event_5", rd_data, 32'h5);
    expect_eq("irq_nomask", 32'(irq), 32'h0);

    // Short pulse on bit 3, well inside one tick period
    sw_in = 10'h00d;
    idle(2);
    sw_in = 10'h005;
    idle(12);
    rd(BASE);
    expect_eq("glitch_level", rd_data, 32'h5);
    rd(BASE + 4);
    expect_eq("glitch_event", rd_data, 32'h5);

    wr(BASE + 8, 32'h1);
    expect_eq("irq_mask_on", 32'(irq), 32'h1);
    wr(BASE + 4, 32'h1);
    expect_eq("irq_clr", 32'(irq), 32'h0);
    rd(BASE + 4);
    expect_eq("event_4", rd_data, 32'h4);

    // Clear bit 1 on exactly the edge where it rises
    sw_in = 10'h007;
    found = 1'b0;
    for (int i = 0; i < 24 && !found; i++) begin
      if ((m_ncyc % DB) == DB - 1 && m_pipe[1][1] &&
          m_prev[1] && !m_lvl[1]) begin
        wr(BASE + 4, 32'h2);
        found = 1'b1;
      end else begin
        cyc();
      end
    end
    expect_eq("rise_found", 32'(found), 32'h1);
    rd(BASE + 4);
    expect_eq("rise_wins", rd_data, 32'h6);

    sw_in = 10'h005;
    idle(12);
    rd(BASE);
    expect_eq("level_back5", rd_data, 32'h5);
    wr(BASE + 8, 32'h4);
    expect_eq("irq_mask4", 32'(irq), 32'h1);
    rd(BASE);
    idle(1);
    rd(BASE);
    expect_eq("pre_rst_rv", 32'(rd_valid), 32'h1);

    #2;
    reset_n = 1'b0;
    #1;
    expect_eq("arst_rd_data", rd_data, 32'h0);
    expect_eq("arst_rd_valid", 32'(rd_valid), 32'h0);
    expect_eq("arst_irq", 32'(irq), 32'h0);
    mdl_reset();
    #20;
    reset_n = 1'b1;
    idle(4);
    rd(BASE);
    expect_eq("lvl_after_tick1", rd_data, 32'h0);
    idle(3);
    rd(BASE);
    expect_eq("lvl_after_tick2", rd_data, 32'h5);
    rd(32'h7fe0);
    expect_eq("bad_adrs_rv", 32'(rd_valid), 32'h0);

    pick[0] = BASE;
    pick[1] = BASE + 4;
    pick[2] = BASE + 8;
    pick[3] = 32'h7ff0;
    pick[4] = 32'h7fe0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) sw_in = W'($urandom);
        else sw_in = sw_in ^ (W'(1) << $urandom_range(0, W - 1));
      end
      pick[5] = $urandom;
      adrs = pick[$urandom_range(0, 5)];
      rd_en = ($urandom_range(0, 1) == 1);
      wr_en = ($urandom_range(0, 9) < 3);
      wr_data = $urandom;
      cyc();
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_input_port.md
Name: dbg_input_port

Overview:
- Memory-mapped input peripheral; the CPU-facing input counterpart of the LED output register at $7ff0.
- Takes raw board switches and buttons, synchronizes and debounces them, and exposes three CPU-readable registers: a level register, a sticky rising-edge event register and an interrupt-mask register.
- Drives a level interrupt request to the CPU.
- Sits between the board pins and the CPU data bus.

Parameters:
- WIDTH, 10, number of input bits (sw[9:0]).
- DB_CYCLES, 50000, clk cycles between debounce samples; must be ≥2.
- CNT_W, 16, width of the sample-tick counter; must satisfy 2^CNT_W > DB_CYCLES.
- BASE_ADRS, 32'h00007ff4, byte address of the level register.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw_in  input  WIDTH  raw, asynchronous switch/button levels; 1 = on.
- adrs  input  32  CPU byte address.
- rd_en  input  1  CPU read strobe, one cycle.
- wr_en  input  1  CPU write strobe, one cycle.
- wr_data  input  32  CPU write data.
- rd_data  output  32  read data; valid when rd_valid is 1.
- rd_valid  output  1  one-cycle pulse, one cycle after an accepted read.
- irq  output  1  registered OR of (EVENT & MASK).

Behaviour:
- Reset (reset_n=0, asynchronous): clear all of the following to 0:
  - synchronizer flops, tick counter, sample registers
  - LEVEL, EVENT, MASK
  - rd_data, rd_valid, irq
- Register map, all zero-extended to 32 bits:
  - BASE+0 LEVEL (read-only)
  - BASE+4 EVENT (read; write-1-to-clear)
  - BASE+8 MASK (read/write)
  - Other addresses are ignored: no rd_valid, no state change.
- Synchronizer: 2-flop synchronizer per bit, giving sw_sync.
- Tick counter:
  - Counts 0 to DB_CYCLES-1, then wraps to 0.
  - tick=1 for the single cycle in which the counter equals DB_CYCLES-1.
- Debounce, on each tick:
  - samp_prev <= sw_sync.
  - For each bit where sw_sync == samp_prev, LEVEL bit <= sw_sync. Otherwise that LEVEL bit holds.
  - A change therefore needs two consecutive equal samples, so latency from a stable input change to LEVEL is 1..2 ticks plus 2 sync cycles.
  - Glitches shorter than one tick period never reach LEVEL.
- Edge capture:
  - rise = LEVEL_next & ~LEVEL.
  - EVENT |= rise (sticky).
  - Falling edges are not recorded.
- Writes (wr_en=1, address match, same cycle):
  - EVENT write: EVENT <= (EVENT & ~wr_data[WIDTH-1:0]) | rise. A new rising edge in the same cycle wins over the clear.
  - MASK write: MASK <= wr_data[WIDTH-1:0].
  - wr_data bits above WIDTH are ignored.
- Reads:
  - rd_en with address match: rd_data <= selected register, rd_valid <= 1 on the next edge.
  - Otherwise rd_valid <= 0 and rd_data holds its previous value.
  - Reads have no side effects.
  - A read and a write to the same register in the same cycle return the pre-write value.
- rd_en and wr_en both set in one cycle: both are performed.
- irq <= |(EVENT_next & MASK_next), so irq is registered and updates 1 cycle after the cause.
  - Writing MASK=0 drops irq on the next cycle.
  - Clearing the last masked event drops irq on the next cycle.
- Reset mid-debounce: all state is lost. The first tick after release only loads samp_prev; LEVEL cannot change until the second tick.

Decomposition:
- Shared package/defines:
  - register offsets: `DBG_IN_LEVEL=0, `DBG_IN_EVENT=4, `DBG_IN_MASK=8
  - default BASE_ADRS 32'h7ff4, next to the existing $7ff0 LED address
- One sub-module: dbg_tick_gen (parameters DB_CYCLES, CNT_W; ports clk, reset_n, tick).
- Synchronizer, debounce, edge capture and bus decode stay in dbg_input_port.

Test Plan:
All scenarios use DB_CYCLES=4, WIDTH=10, BASE=32'h7ff4.
- Reset, then read 7ff4, 7ff8, 7ffc -> each read returns 0 with a rd_valid pulse 1 cycle after rd_en; irq=0.
- Hold sw_in=10'h005 stable -> LEVEL=32'h5 within 2 sync + 8 cycles; EVENT=32'h5; irq stays 0 with MASK=0.
- Toggle sw_in[3] for 2 cycles between ticks -> LEVEL[3] and EVENT[3] never set.
- Write MASK=32'h1 with EVENT[0]=1 -> irq=1 the next cycle; write EVENT=32'h1 -> EVENT=32'h4 and irq=0 the next cycle.
- Write EVENT=32'h2 in the same cycle that bit 1 rises -> EVENT[1] stays 1.
- Assert reset_n=0 mid-count with LEVEL=32'h5 -> all outputs 0 immediately (asynchronous); after release, LEVEL stays 0 until the second tick; read of 32'h7fe0 -> no rd_valid.
